ysyx_23060025_rd_arbiter: RTL and testbench
===========================================

YSYX_23060025_RD_ARBITER -- requirements
Module: ysyx_23060025_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 3, number of read requesters (0=IFU, 1=LSU, 2=prefetch).
REQ-002 SHALL have parameter ADDR_LEN, default 32, address width.
REQ-003 SHALL have parameter DATA_LEN, default 32, data width.
REQ-004 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port m_arvalid_i  input  NUM_M  per-requester read-address valid.
REQ-007 SHALL have port m_araddr_i  input  NUM_M*ADDR_LEN  packed addresses; slice i belongs to requester i.
REQ-008 SHALL have port m_arlen_i  input  NUM_M*8  packed burst lengths.
REQ-009 SHALL have port m_arsize_i  input  NUM_M*3  packed beat sizes.
REQ-010 SHALL have port m_arready_o  output  NUM_M  per-requester address accept.
REQ-011 SHALL have port m_rdata_o  output  DATA_LEN  read data, broadcast to all requesters.
REQ-012 SHALL have port m_rvalid_o / m_rlast_o  output  NUM_M each  beat valid and last beat, owner only.
REQ-013 SHALL have port m_rready_i  input  NUM_M  per-requester data ready.
REQ-014 SHALL have ports s_arvalid_o, s_araddr_o, s_arlen_o, s_arsize_o (outputs) and s_arready_i (input): downstream AR channel, AXI widths.
REQ-015 SHALL have ports s_rdata_i, s_rvalid_i, s_rlast_i (inputs) and s_rready_o (output): downstream R channel.
REQ-016 SHALL have port err_timeout_o  output  1  sticky read-timeout flag.

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA.
REQ-018 IDLE: when any m_arvalid_i bit is set, SHALL latch grant = first set index searching circularly from ptr+1, then go to ADDR on the next cycle.
REQ-019 ADDR: SHALL drive the s_ar* outputs from the granted slice, with s_arvalid_o = m_arvalid_i[grant].
REQ-020 ADDR: SHALL drive m_arready_o[grant] = s_arready_i, with all other m_arready_o bits 0.
REQ-021 ADDR: SHALL move to DATA on s_arvalid_o & s_arready_i.
REQ-022 DATA: SHALL route m_rvalid_o[grant] = s_rvalid_i, m_rlast_o[grant] = s_rlast_i, and s_rready_o = m_rready_i[grant]; all non-owner bits SHALL be 0.
REQ-023 DATA: on s_rvalid_i & s_rready_o & s_rlast_i, SHALL set ptr <= grant and go to IDLE.
REQ-024 Minimum cost SHALL be one idle cycle per burst; back-to-back bursts are separated by exactly one IDLE cycle.
REQ-025 Requests arriving during ADDR or DATA SHALL wait and SHALL NOT alter the grant.
REQ-026 A requester deasserting m_arvalid_i in ADDR is a protocol violation; the arbiter SHALL hold grant regardless.
REQ-027 A requester re-requesting right after its own burst SHALL yield to any other pending requester.
REQ-028 s_arvalid_o and s_rready_o SHALL be 0 in IDLE.

Reset
REQ-029 On reset, including mid-burst, state SHALL <= IDLE, ptr <= NUM_M-1 (requester 0 wins first), grant <= 0, err_timeout_o <= 0.
REQ-030 All handshake outputs SHALL be 0 in the cycle after reset.

Configuration
REQ-031 With RD_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on state entry and on each R beat, and increment every ADDR/DATA cycle otherwise.
REQ-032 With RD_ARB_TIMEOUT_EN defined, when the counter reaches 255 the block SHALL set err_timeout_o (sticky until reset) and force state to IDLE.
REQ-033 Without RD_ARB_TIMEOUT_EN, the counter SHALL be absent and err_timeout_o SHALL be tied to 0.

Structure
REQ-034 State encodings and the timeout limit (255) SHALL be defined in ysyx_23060025_define.v.
REQ-035 The circular priority search SHALL be a sub-module, ysyx_23060025_rr_picker (inputs: request vector, ptr; output: grant index and any-valid).

Verification
REQ-036 Reset, then m_arvalid_i=3'b111 held -> grants observed in order 0,1,2,0 across four 1-beat bursts.
REQ-037 Only requester 1 requests, addr 0x8000_0000, len 3 -> s_araddr_o=0x8000_0000, s_arlen_o=3; four beats reach m_rvalid_o[1] only, m_rlast_o[1] on the 4th; return to IDLE.
REQ-038 s_arready_i held low 5 cycles in ADDR -> s_ar* stable, m_arready_o=0, no state change until handshake.
REQ-039 Reset asserted mid-DATA (beat 2 of 4) -> next cycle IDLE, outputs 0, next grant goes to requester 0.
REQ-040 Requester 0 re-requests right after its burst while requester 2 pending -> requester 2 granted.
REQ-041 RD_ARB_TIMEOUT_EN defined, s_rvalid_i never asserted -> err_timeout_o=1 after 255 cycles, state IDLE; without the macro err_timeout_o stays 0.

Source files
------------

// File: rtl/ysyx_23060025_rd_arbiter_pkg.sv
// Shared constants for the read arbiter: FSM state encodings and the read-timeout limit.
package ysyx_23060025_rd_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [7:0] RD_ARB_TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/ysyx_23060025_rd_arbiter_rr_picker.sv
// Circular priority search: first requester set, scanning upward from ptr+1 and wrapping.
module ysyx_23060025_rr_picker #(
  parameter int NUM_M = 3,
  parameter int IDX_W = 2
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand [NUM_M];

  // cand[k] is the requester at circular distance k+1 from ptr, so the owner itself is tried last
  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_cand
      assign cand[gi] = IDX_W'((int'(ptr_i) + gi + 1) % NUM_M);
    end
  endgenerate

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        grant_o = cand[k];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060025_rd_arbiter.sv
// Round-robin arbiter sharing one downstream AXI read channel among NUM_M requesters.
// Optional watchdog enabled by defining RD_ARB_TIMEOUT_EN.
module ysyx_23060025_rd_arbiter
  import ysyx_23060025_rd_arbiter_pkg::*;
#(
  parameter int NUM_M    = 3,
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_M-1:0]          m_arvalid_i,
  input  logic [NUM_M*ADDR_LEN-1:0] m_araddr_i,
  input  logic [NUM_M*8-1:0]        m_arlen_i,
  input  logic [NUM_M*3-1:0]        m_arsize_i,
  output logic [NUM_M-1:0]          m_arready_o,
  output logic [DATA_LEN-1:0]       m_rdata_o,
  output logic [NUM_M-1:0]          m_rvalid_o,
  output logic [NUM_M-1:0]          m_rlast_o,
  input  logic [NUM_M-1:0]          m_rready_i,
  output logic                      s_arvalid_o,
  output logic [ADDR_LEN-1:0]       s_araddr_o,
  output logic [7:0]                s_arlen_o,
  output logic [2:0]                s_arsize_o,
  input  logic                      s_arready_i,
  input  logic [DATA_LEN-1:0]       s_rdata_i,
  input  logic                      s_rvalid_i,
  input  logic                      s_rlast_i,
  output logic                      s_rready_o,
  output logic                      err_timeout_o
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  logic [1:0]       state_q, state_d, fsm_next;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] pick_grant;
  logic             pick_valid;
  logic             ar_fire;
  logic             r_beat;
  logic             timeout_hit;

  logic [ADDR_LEN-1:0] addr_arr [NUM_M];
  logic [7:0]          len_arr  [NUM_M];
  logic [2:0]          size_arr [NUM_M];

  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign addr_arr[gi] = m_araddr_i[gi*ADDR_LEN +: ADDR_LEN];
      assign len_arr[gi]  = m_arlen_i[gi*8 +: 8];
      assign size_arr[gi] = m_arsize_i[gi*3 +: 3];
    end
  endgenerate

  ysyx_23060025_rr_picker #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (m_arvalid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  assign ar_fire   = (state_q == ST_ADDR) && m_arvalid_i[grant_q] && s_arready_i;
  assign r_beat    = (state_q == ST_DATA) && s_rvalid_i && m_rready_i[grant_q];
  assign m_rdata_o = s_rdata_i;

  always_comb begin
    fsm_next    = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    m_arready_o = '0;
    m_rvalid_o  = '0;
    m_rlast_o   = '0;
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    s_araddr_o  = addr_arr[grant_q];
    s_arlen_o   = len_arr[grant_q];
    s_arsize_o  = size_arr[grant_q];
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_grant;
          fsm_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // grant is held even if the requester drops valid; it simply stalls here
        s_arvalid_o          = m_arvalid_i[grant_q];
        m_arready_o[grant_q] = s_arready_i;
        if (ar_fire) fsm_next = ST_DATA;
      end
      ST_DATA: begin
        m_rvalid_o[grant_q] = s_rvalid_i;
        m_rlast_o[grant_q]  = s_rlast_i;
        s_rready_o          = m_rready_i[grant_q];
        if (r_beat && s_rlast_i) begin
          ptr_d    = grant_q;
          fsm_next = ST_IDLE;
        end
      end
      default: fsm_next = ST_IDLE;
    endcase
    state_d = timeout_hit ? ST_IDLE : fsm_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RD_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign timeout_hit   = (state_q != ST_IDLE) && (cnt_q == RD_ARB_TIMEOUT_LIMIT);
  assign err_timeout_o = err_q;

  // restarts on every state change and every delivered beat, so only a true stall can expire
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_hit;
    if ((state_d != state_q) || r_beat) begin
      cnt_d = '0;
    end else if (state_q != ST_IDLE) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Self-checking bench for ysyx_23060025_rd_arbiter: directed scenarios plus randomized traffic.
module tb_ysyx_23060025_rd_arbiter;

  localparam int NUM_M = 3;
  localparam int AL    = 32;
  localparam int DL    = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_M-1:0]  m_arvalid_i;
  logic [NUM_M*AL-1:0] m_araddr_i;
  logic [NUM_M*8-1:0]  m_arlen_i;
  logic [NUM_M*3-1:0]  m_arsize_i;
  logic [NUM_M-1:0]  m_arready_o;
  logic [DL-1:0]     m_rdata_o;
  logic [NUM_M-1:0]  m_rvalid_o;
  logic [NUM_M-1:0]  m_rlast_o;
  logic [NUM_M-1:0]  m_rready_i;
  logic              s_arvalid_o;
  logic [AL-1:0]     s_araddr_o;
  logic [7:0]        s_arlen_o;
  logic [2:0]        s_arsize_o;
  logic              s_arready_i;
  logic [DL-1:0]     s_rdata_i;
  logic              s_rvalid_i;
  logic              s_rlast_i;
  logic              s_rready_o;
  logic              err_timeout_o;

  int total = 0;
  int bad   = 0;

  ysyx_23060025_rd_arbiter #(.NUM_M(NUM_M), .ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid_i(m_arvalid_i), .m_araddr_i(m_araddr_i), .m_arlen_i(m_arlen_i),
    .m_arsize_i(m_arsize_i), .m_arready_o(m_arready_o), .m_rdata_o(m_rdata_o),
    .m_rvalid_o(m_rvalid_o), .m_rlast_o(m_rlast_o), .m_rready_i(m_rready_i),
    .s_arvalid_o(s_arvalid_o), .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
    .s_arsize_o(s_arsize_o), .s_arready_i(s_arready_i), .s_rdata_i(s_rdata_i),
    .s_rvalid_i(s_rvalid_i), .s_rlast_i(s_rlast_i), .s_rready_o(s_rready_o),
    .err_timeout_o(err_timeout_o)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference arbitration rule: first pending requester after the last owner, wrapping.
  function automatic int rr_next(int last, logic [NUM_M-1:0] pend);
    for (int k = 1; k <= NUM_M; k++) begin
      if (pend[(last + k) % NUM_M]) return (last + k) % NUM_M;
    end
    return -1;
  endfunction

  task automatic nxt();
    @(posedge clock); #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    m_araddr_i[i*AL +: AL] = a;
    m_arlen_i[i*8 +: 8]    = l;
    m_arsize_i[i*3 +: 3]   = s;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    m_arvalid_i = '0; m_araddr_i = '0; m_arlen_i = '0; m_arsize_i = '0;
    m_rready_i = '0; s_arready_i = 1'b0; s_rdata_i = '0; s_rvalid_i = 1'b0; s_rlast_i = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_req(0, 32'h0000_1000, 8'd0, 3'd2);
    set_req(1, 32'h0000_2000, 8'd0, 3'd2);
    set_req(2, 32'h0000_3000, 8'd0, 3'd2);
    m_arvalid_i = 3'b111; s_arready_i = 1'b1; m_rready_i = 3'b111;
    s_rvalid_i = 1'b1; s_rlast_i = 1'b1;
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    smp();
    total++;
    if ({s_arvalid_o, s_rready_o, m_arready_o, m_rvalid_o, m_rlast_o} !== 11'b0) begin
      bad++;
      $display("FAIL reset_outputs: got arv=%b rrdy=%b arrdy=%b rv=%b rl=%b want all 0",
               s_arvalid_o, s_rready_o, m_arready_o, m_rvalid_o, m_rlast_o);
    end
    total++;
    if (err_timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want 0", err_timeout_o);
    end
    nxt(); smp();
    total++;
    if (m_arready_o !== 3'b001 || s_araddr_o !== 32'h0000_1000) begin
      bad++;
      $display("FAIL reset_first_grant: got arready=%b addr=%h want 001 00001000", m_arready_o, s_araddr_o);
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_seq[4] = '{0, 1, 2, 0};
    int last_hs = -1;
    int g;
    do_reset();
    for (int i = 0; i < NUM_M; i++) set_req(i, 32'h1000_0000 + 32'(i) * 32'h100, 8'd0, 3'd2);
    m_arvalid_i = 3'b111; s_arready_i = 1'b1; m_rready_i = 3'b111;
    s_rvalid_i = 1'b1; s_rlast_i = 1'b1;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      smp();
      if (s_arvalid_o && s_arready_i) begin
        g = -1;
        for (int i = 0; i < NUM_M; i++) if (m_arready_o[i]) g = i;
        got.push_back(g);
        total++;
        if (!$onehot(m_arready_o) || g < 0 || s_araddr_o !== 32'h1000_0000 + 32'(g) * 32'h100) begin
          bad++;
          $display("FAIL rr_addr: got arready=%b addr=%h want one-hot with matching address", m_arready_o, s_araddr_o);
        end
        if (last_hs >= 0) begin
          total++;
          if (c - last_hs != 3) begin
            bad++;
            $display("FAIL rr_spacing: got %0d cycles between grants want 3", c - last_hs);
          end
        end
        $display("rr grant %0d -> requester %0d at cycle %0d", got.size() - 1, g, c);
        last_hs = c;
      end
      nxt();
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL rr_count: got %0d grants want 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] != exp_seq[i]) begin
        bad++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_single_burst();
    logic [31:0] d;
    do_reset();
    set_req(1, 32'h8000_0000, 8'd3, 3'd2);
    m_arvalid_i = 3'b010; s_arready_i = 1'b1; m_rready_i = 3'b111;
    smp();
    total++;
    if (s_arvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got arvalid=%b want 0", s_arvalid_o);
    end
    nxt(); smp();
    total++;
    if (s_arvalid_o !== 1'b1 || s_araddr_o !== 32'h8000_0000 || s_arlen_o !== 8'd3 || m_arready_o !== 3'b010) begin
      bad++;
      $display("FAIL single_addr: got arv=%b addr=%h len=%0d arrdy=%b want 1 80000000 3 010",
               s_arvalid_o, s_araddr_o, s_arlen_o, m_arready_o);
    end
    for (int b = 0; b < 4; b++) begin
      nxt();
      m_arvalid_i = 3'b000;
      d = 32'hA5A5_0000 + 32'(b);
      s_rdata_i = d; s_rvalid_i = 1'b1; s_rlast_i = (b == 3);
      smp();
      total++;
      if (m_rvalid_o !== 3'b010 || m_rlast_o !== ((b == 3) ? 3'b010 : 3'b000) ||
          m_rdata_o !== d || s_rready_o !== 1'b1) begin
        bad++;
        $display("FAIL single_beat%0d: got rv=%b rl=%b data=%h rrdy=%b want 010 %b %h 1",
                 b, m_rvalid_o, m_rlast_o, m_rdata_o, s_rready_o, (b == 3) ? 3'b010 : 3'b000, d);
      end
    end
    nxt();
    s_rlast_i = 1'b0;
    smp();
    total++;
    if (m_rvalid_o !== 3'b000 || s_rready_o !== 1'b0 || s_arvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_back_idle: got rv=%b rrdy=%b arv=%b want 000 0 0", m_rvalid_o, s_rready_o, s_arvalid_o);
    end
  endtask

  task automatic test_addr_stall();
    do_reset();
    set_req(0, 32'h1234_5670, 8'd1, 3'd2);
    m_arvalid_i = 3'b001; s_arready_i = 1'b0; m_rready_i = 3'b111;
    s_rvalid_i = 1'b1; s_rlast_i = 1'b0;
    nxt();
    for (int c = 0; c < 5; c++) begin
      smp();
      total++;
      if (s_arvalid_o !== 1'b1 || s_araddr_o !== 32'h1234_5670 || s_arlen_o !== 8'd1 ||
          m_arready_o !== 3'b000 || m_rvalid_o !== 3'b000) begin
        bad++;
        $display("FAIL stall_cycle%0d: got arv=%b addr=%h len=%0d arrdy=%b rv=%b want 1 12345670 1 000 000",
                 c, s_arvalid_o, s_araddr_o, s_arlen_o, m_arready_o, m_rvalid_o);
      end
      nxt();
    end
    s_arready_i = 1'b1;
    smp();
    total++;
    if (m_arready_o !== 3'b001) begin
      bad++;
      $display("FAIL stall_release: got arready=%b want 001", m_arready_o);
    end
    nxt();
    m_arvalid_i = 3'b000;
    smp();
    total++;
    if (m_rvalid_o !== 3'b001 || s_arvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_data: got rv=%b arv=%b want 001 0", m_rvalid_o, s_arvalid_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 32'h0000_0A00, 8'd0, 3'd2);
    m_arvalid_i = 3'b001; s_arready_i = 1'b1; m_rready_i = 3'b111;
    nxt();
    nxt();
    m_arvalid_i = 3'b000; s_rvalid_i = 1'b1; s_rlast_i = 1'b1;
    nxt();
    s_rvalid_i = 1'b0; s_rlast_i = 1'b0;
    set_req(2, 32'h0000_0C00, 8'd3, 3'd2);
    m_arvalid_i = 3'b100;
    nxt();
    nxt();
    m_arvalid_i = 3'b000; s_rvalid_i = 1'b1;
    smp();
    total++;
    if (m_rvalid_o !== 3'b100) begin
      bad++;
      $display("FAIL midrst_beat1: got rv=%b want 100", m_rvalid_o);
    end
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    set_req(1, 32'h0000_0B00, 8'd0, 3'd2);
    m_arvalid_i = 3'b111;
    smp();
    total++;
    if ({s_arvalid_o, s_rready_o, m_arready_o, m_rvalid_o, m_rlast_o} !== 11'b0) begin
      bad++;
      $display("FAIL midrst_outputs: got arv=%b rrdy=%b arrdy=%b rv=%b rl=%b want all 0",
               s_arvalid_o, s_rready_o, m_arready_o, m_rvalid_o, m_rlast_o);
    end
    nxt(); smp();
    total++;
    if (m_arready_o !== 3'b001 || s_araddr_o !== 32'h0000_0A00) begin
      bad++;
      $display("FAIL midrst_grant: got arready=%b addr=%h want 001 00000a00", m_arready_o, s_araddr_o);
    end
  endtask

  task automatic test_yield();
    do_reset();
    set_req(0, 32'h0000_5000, 8'd0, 3'd2);
    set_req(2, 32'h0000_7000, 8'd0, 3'd2);
    m_arvalid_i = 3'b001; s_arready_i = 1'b1; m_rready_i = 3'b111;
    nxt();
    m_arvalid_i = 3'b101;
    smp();
    total++;
    if (m_arready_o !== 3'b001 || s_araddr_o !== 32'h0000_5000) begin
      bad++;
      $display("FAIL yield_hold: got arready=%b addr=%h want 001 00005000", m_arready_o, s_araddr_o);
    end
    nxt();
    s_rvalid_i = 1'b1; s_rlast_i = 1'b1;
    smp();
    total++;
    if (m_rvalid_o !== 3'b001 || m_rlast_o !== 3'b001) begin
      bad++;
      $display("FAIL yield_data: got rv=%b rl=%b want 001 001", m_rvalid_o, m_rlast_o);
    end
    nxt();
    s_rvalid_i = 1'b0; s_rlast_i = 1'b0;
    smp();
    total++;
    if (s_arvalid_o !== 1'b0 || s_rready_o !== 1'b0) begin
      bad++;
      $display("FAIL yield_idle: got arv=%b rrdy=%b want 0 0", s_arvalid_o, s_rready_o);
    end
    nxt(); smp();
    total++;
    if (m_arready_o !== 3'b100 || s_araddr_o !== 32'h0000_7000) begin
      bad++;
      $display("FAIL yield_grant: got arready=%b addr=%h want 100 00007000", m_arready_o, s_araddr_o);
    end
  endtask

  task automatic test_random();
    logic [NUM_M-1:0] pend;
    logic [31:0] raddr [NUM_M];
    logic [7:0]  rlen  [NUM_M];
    logic [2:0]  rsize [NUM_M];
    logic [NUM_M-1:0] exp_v;
    int ptr_m = NUM_M - 1;
    int owner = 0;
    int beats = 0;
    int bursts = 0;
    bit free = 1'b1;
    bit in_addr = 1'b0;
    pend = '0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      nxt();
      for (int i = 0; i < NUM_M; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1'b1;
          raddr[i] = $urandom;
          rlen[i]  = 8'($urandom_range(0, 3));
          rsize[i] = 3'($urandom_range(0, 3));
          set_req(i, raddr[i], rlen[i], rsize[i]);
        end
      end
      m_arvalid_i = pend;
      s_arready_i = 1'($urandom_range(0, 1));
      m_rready_i  = 3'($urandom);
      s_rvalid_i  = 1'($urandom_range(0, 1));
      s_rlast_i   = (beats > 0) ? (beats == 1) : 1'($urandom_range(0, 1));
      s_rdata_i   = $urandom;
      smp();
      total++;
      if (m_rdata_o !== s_rdata_i) begin
        bad++;
        $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, m_rdata_o, s_rdata_i);
      end
      if (free) begin
        total++;
        if ({s_arvalid_o, s_rready_o, m_arready_o, m_rvalid_o, m_rlast_o} !== 11'b0) begin
          bad++;
          $display("FAIL rnd_idle cyc%0d: got arv=%b rrdy=%b arrdy=%b rv=%b rl=%b want all 0",
                   cyc, s_arvalid_o, s_rready_o, m_arready_o, m_rvalid_o, m_rlast_o);
        end
        if (pend != '0) begin
          owner   = rr_next(ptr_m, pend);
          free    = 1'b0;
          in_addr = 1'b1;
        end
      end else if (in_addr) begin
        exp_v = s_arready_i ? (3'b001 << owner) : 3'b000;
        total++;
        if (s_arvalid_o !== 1'b1 || s_araddr_o !== raddr[owner] || s_arlen_o !== rlen[owner] ||
            s_arsize_o !== rsize[owner] || m_arready_o !== exp_v || s_rready_o !== 1'b0 || m_rvalid_o !== 3'b000) begin
          bad++;
          $display("FAIL rnd_addr cyc%0d: got arv=%b addr=%h len=%0d size=%0d arrdy=%b want 1 %h %0d %0d %b (owner %0d)",
                   cyc, s_arvalid_o, s_araddr_o, s_arlen_o, s_arsize_o, m_arready_o,
                   raddr[owner], rlen[owner], rsize[owner], exp_v, owner);
        end
        if (s_arready_i) begin
          pend[owner] = 1'b0;
          beats   = int'(rlen[owner]) + 1;
          in_addr = 1'b0;
        end
      end else begin
        exp_v = s_rvalid_i ? (3'b001 << owner) : 3'b000;
        total++;
        if (m_rvalid_o !== exp_v || m_rlast_o !== (s_rlast_i ? (3'b001 << owner) : 3'b000) ||
            s_rready_o !== m_rready_i[owner] || s_arvalid_o !== 1'b0 || m_arready_o !== 3'b000) begin
          bad++;
          $display("FAIL rnd_data cyc%0d: got rv=%b rl=%b rrdy=%b arv=%b want rv=%b rrdy=%b (owner %0d)",
                   cyc, m_rvalid_o, m_rlast_o, s_rready_o, s_arvalid_o, exp_v, m_rready_i[owner], owner);
        end
        if (s_rvalid_i && m_rready_i[owner]) begin
          beats--;
          if (beats == 0) begin
            $display("burst done: owner=%0d len=%0d cyc=%0d", owner, rlen[owner], cyc);
            ptr_m = owner;
            free  = 1'b1;
            bursts++;
          end
        end
      end
    end
    total++;
    if (bursts < 20) begin
      bad++;
      $display("FAIL rnd_progress: got %0d bursts want at least 20", bursts);
    end
  endtask

  task automatic test_timeout();
    int hit = -1;
    do_reset();
    set_req(1, 32'h0000_9000, 8'd3, 3'd2);
    m_arvalid_i = 3'b010; s_arready_i = 1'b1; m_rready_i = 3'b111;
    nxt();
    nxt();
    m_arvalid_i = 3'b000;
    for (int c = 0; c < 300 && hit < 0; c++) begin
      smp();
      if (err_timeout_o === 1'b1) hit = c;
      else nxt();
    end
`ifdef RD_ARB_TIMEOUT_EN
    total++;
    if (hit < 250 || hit > 260) begin
      bad++;
      $display("FAIL timeout_flag: got rise at cycle %0d want about 256", hit);
    end
    total++;
    if (s_rready_o !== 1'b0 || s_arvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: got rrdy=%b arv=%b want 0 0", s_rready_o, s_arvalid_o);
    end
`else
    total++;
    if (hit >= 0 || err_timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_tied: got err=%b at cycle %0d want 0", err_timeout_o, hit);
    end
    total++;
    if (s_rready_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_wait: got rrdy=%b want 1 (still in data)", s_rready_o);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    m_arvalid_i = '0; m_araddr_i = '0; m_arlen_i = '0; m_arsize_i = '0;
    m_rready_i = '0; s_arready_i = 1'b0; s_rdata_i = '0; s_rvalid_i = 1'b0; s_rlast_i = 1'b0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_addr_stall();
    test_reset_mid_burst();
    test_yield();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
